// File: rtl/pmc_frame_pkg.sv
// rtl/pmc_frame_pkg.sv - shared PMC frame constants, field offsets and assembler state type
package pmc_frame_pkg;

    localparam logic [7:0] START_BYTE  = 8'h0F;
    localparam logic [7:0] END_BYTE    = 8'hF0;
    localparam int         FRAME_BYTES = 12;
    localparam int         FRAME_BITS  = FRAME_BYTES * 8;

    // Bit offsets (LSB) of each field inside the 96-bit frame word
    localparam int START_LSB  = 88;
    localparam int HEADER_LSB = 72;
    localparam int DATA_LSB   = 40;
    localparam int ADDR_LSB   = 16;
    localparam int ERROR_LSB  = 8;
    localparam int END_LSB    = 0;

    // Header codes, interpreted downstream by the decoder
    localparam logic [15:0] HDR_READ  = 16'h0001;
    localparam logic [15:0] HDR_WRITE = 16'h0002;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/pmc_rx_frame_assembler_if.sv
// rtl/pmc_rx_frame_assembler_if.sv - byte-in / frame-out bus of the PMC frame assembler
// master: UART receiver + decoder side (drives bytes and clear)
// slave : the assembler (drives frame word, flag, error/overrun pulses, frame count)
interface pmc_rx_frame_assembler_if;
    logic [7:0]  iRxData;
    logic        iRxValid;
    logic        iClear;
    logic [95:0] oMsg;
    logic        oRxFlag;
    logic        oFrameErr;
    logic        oOverrun;
    logic [7:0]  oFrameCnt;

    modport master (
        output iRxData, iRxValid, iClear,
        input  oMsg, oRxFlag, oFrameErr, oOverrun, oFrameCnt
    );

    modport slave (
        input  iRxData, iRxValid, iClear,
        output oMsg, oRxFlag, oFrameErr, oOverrun, oFrameCnt
    );
endinterface

// File: rtl/pmc_byte_gap_timer.sv
// rtl/pmc_byte_gap_timer.sv - inter-byte idle timer with expiry pulse
// Ports: clk, reset (sync active-low), en (count while high, cleared while low),
//        restart (clear count; masks expiry), expire (combinational one-cycle pulse)
module pmc_byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic restart,
    output logic expire
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Expires on the TIMEOUT_CYCLES-th idle clock; a byte on that same clock wins.
    assign expire = en && !restart && (cnt_q == W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (!en || restart || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pmc_rx_frame_assembler.sv
// rtl/pmc_rx_frame_assembler.sv - assembles 12-byte PMC frames from the UART byte stream
// Ports: clk, reset (sync active-low), bus (pmc_rx_frame_assembler_if.slave):
//        iRxData/iRxValid byte strobe, iClear release, oMsg frame word, oRxFlag held flag,
//        oFrameErr / oOverrun one-cycle pulses, oFrameCnt good-frame count.
// Build option: PMC_RX_TIMEOUT_EN enables the inter-byte timeout in COLLECT.
module pmc_rx_frame_assembler
    import pmc_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    reset,
    pmc_rx_frame_assembler_if.slave bus
);
    rx_state_e   state_q, state_d;
    logic [87:0] shift_q, shift_d;      // first eleven bytes; byte twelve comes straight off the bus
    logic [3:0]  cnt_q, cnt_d;
    logic [95:0] msg_q, msg_d;
    logic        rx_flag_q, rx_flag_d;
    logic        frame_err_q, frame_err_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic accept;
    logic timeout;
    logic hunting;

`ifdef PMC_RX_TIMEOUT_EN
    pmc_byte_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .en      (state_q == COLLECT),
        .restart (accept),
        .expire  (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // A clear in HOLD hands the same cycle's byte to the hunt logic.
    assign hunting = (state_q == HUNT) || ((state_q == HOLD) && bus.iClear);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        rx_flag_d   = rx_flag_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        accept      = 1'b0;

        case (state_q)
            COLLECT: begin
                if (bus.iRxValid) begin
                    accept  = 1'b1;
                    shift_d = {shift_q[79:0], bus.iRxData};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'(FRAME_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = HUNT;
                        if (bus.iRxData == END_BYTE) begin
                            msg_d       = {shift_q, bus.iRxData};
                            rx_flag_d   = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = HOLD;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = HUNT;
                end
            end
            HOLD: begin
                if (bus.iClear) begin
                    rx_flag_d = 1'b0;
                    state_d   = HUNT;
                end else if (bus.iRxValid) begin
                    overrun_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (hunting && bus.iRxValid && (bus.iRxData == START_BYTE)) begin
            shift_d = {80'd0, bus.iRxData};
            cnt_d   = 4'd1;
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= HUNT;
            shift_q     <= '0;
            cnt_q       <= '0;
            msg_q       <= '0;
            rx_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            rx_flag_q   <= rx_flag_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.oMsg      = msg_q;
    assign bus.oRxFlag   = rx_flag_q;
    assign bus.oFrameErr = frame_err_q;
    assign bus.oOverrun  = overrun_q;
    assign bus.oFrameCnt = frame_cnt_q;
endmodule

// File: tb/tb_pmc_rx_frame_assembler.sv
// tb/tb_pmc_rx_frame_assembler.sv - directed self-checking bench for pmc_rx_frame_assembler
module tb_pmc_rx_frame_assembler;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    int   err_cnt = 0;
    int   ov_cnt  = 0;

    pmc_rx_frame_assembler_if bus ();

    pmc_rx_frame_assembler #(.TIMEOUT_CYCLES(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count high samples of the pulse outputs; a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (bus.oFrameErr === 1'b1) err_cnt++;
        if (bus.oOverrun === 1'b1) ov_cnt++;
    end

    localparam logic [95:0] FRAME_A = 96'h0F0002DEADBEEF12345600F0;
    localparam logic [95:0] FRAME_B = 96'h0F000111223344ABCDEF5AF0;
    localparam logic [95:0] FRAME_C = 96'h0F000100000001ABCDEF00EE;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one sampling edge; returns 1ns after that edge.
    task automatic put_byte(input logic [7:0] b);
        bus.iRxValid = 1'b1;
        bus.iRxData  = b;
        @(posedge clk); #1;
        bus.iRxValid = 1'b0;
        bus.iRxData  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [95:0] f, input int first, input int last, input int gap);
        logic [95:0] tmp;
        tmp = f;
        for (int i = first; i <= last; i++) begin
            put_byte(tmp[95 - 8*i -: 8]);
            if (gap > 0 && i != last) idle(gap);
        end
    endtask

    task automatic pulse_clear();
        bus.iClear = 1'b1;
        @(posedge clk); #1;
        bus.iClear = 1'b0;
    endtask

    initial begin
        int e0;
        bus.iRxData  = 8'h00;
        bus.iRxValid = 1'b0;
        bus.iClear   = 1'b0;

        idle(3);
        check("rst_msg",   bus.oMsg, 96'd0);
        check("rst_flag",  {95'd0, bus.oRxFlag}, 96'd0);
        check("rst_err",   {95'd0, bus.oFrameErr}, 96'd0);
        check("rst_ovr",   {95'd0, bus.oOverrun}, 96'd0);
        check("rst_cnt",   {88'd0, bus.oFrameCnt}, 96'd0);
        reset = 1'b1;
        idle(2);

        // Good write frame, one byte per 4 clocks
        send_frame(FRAME_A, 0, 11, 3);
        check("a_flag", {95'd0, bus.oRxFlag}, 96'd1);
        check("a_msg",  bus.oMsg, FRAME_A);
        check("a_cnt",  {88'd0, bus.oFrameCnt}, 96'd1);
        check("a_noerr", 96'(err_cnt), 96'd0);

        // Bytes in HOLD are dropped with an overrun each
        put_byte(8'h11); put_byte(8'h22); idle(1); put_byte(8'h0F);
        idle(1);
        check("ovr_cnt",  96'(ov_cnt), 96'd3);
        check("ovr_msg",  bus.oMsg, FRAME_A);
        check("ovr_flag", {95'd0, bus.oRxFlag}, 96'd1);

        // Clear together with a start byte: clear wins, byte starts a new frame
        bus.iClear = 1'b1;
        put_byte(8'h0F);
        bus.iClear = 1'b0;
        check("clr_flag", {95'd0, bus.oRxFlag}, 96'd0);
        check("clr_novr", 96'(ov_cnt), 96'd3);
        send_frame(FRAME_B, 1, 11, 0);
        check("b_flag", {95'd0, bus.oRxFlag}, 96'd1);
        check("b_msg",  bus.oMsg, FRAME_B);
        check("b_cnt",  {88'd0, bus.oFrameCnt}, 96'd2);

        // Noise, then the good frame back-to-back
        pulse_clear();
        check("clr2_flag", {95'd0, bus.oRxFlag}, 96'd0);
        put_byte(8'h55); put_byte(8'hAA);
        send_frame(FRAME_A, 0, 11, 0);
        check("n_msg",   bus.oMsg, FRAME_A);
        check("n_cnt",   {88'd0, bus.oFrameCnt}, 96'd3);
        check("n_noerr", 96'(err_cnt), 96'd0);

        // Bad end byte
        pulse_clear();
        send_frame(FRAME_C, 0, 11, 0);
        check("bad_errnow", {95'd0, bus.oFrameErr}, 96'd1);
        idle(2);
        check("bad_errcnt", 96'(err_cnt), 96'd1);
        check("bad_flag",   {95'd0, bus.oRxFlag}, 96'd0);
        check("bad_msg",    bus.oMsg, FRAME_A);
        check("bad_cnt",    {88'd0, bus.oFrameCnt}, 96'd3);

`ifdef PMC_RX_TIMEOUT_EN
        // Stall after 5 bytes; expiry on the 50th idle clock
        e0 = err_cnt;
        send_frame(FRAME_A, 0, 4, 0);
        idle(49);
        check("to_early", {95'd0, bus.oFrameErr}, 96'd0);
        idle(1);
        check("to_err",   {95'd0, bus.oFrameErr}, 96'd1);
        idle(2);
        check("to_errcnt", 96'(err_cnt - e0), 96'd1);
        send_frame(FRAME_B, 0, 11, 0);
        check("to_msg", bus.oMsg, FRAME_B);
        check("to_cnt", {88'd0, bus.oFrameCnt}, 96'd4);
        pulse_clear();
`else
        e0 = err_cnt;
`endif

        // Reset mid-frame
        send_frame(FRAME_B, 0, 5, 0);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        check("mrst_msg",  bus.oMsg, 96'd0);
        check("mrst_flag", {95'd0, bus.oRxFlag}, 96'd0);
        check("mrst_cnt",  {88'd0, bus.oFrameCnt}, 96'd0);
        check("mrst_err",  {95'd0, bus.oFrameErr}, 96'd0);
        e0 = err_cnt;
        send_frame(FRAME_A, 0, 11, 0);
        check("post_msg", bus.oMsg, FRAME_A);
        check("post_cnt", {88'd0, bus.oFrameCnt}, 96'd1);
        idle(2);
        check("post_noerr", 96'(err_cnt - e0), 96'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
